// File: rtl/booth_pkg.sv
// Shared constants and op-priority decode for the Booth shift register.
package booth_pkg;

    localparam int BOOTH_W = 16;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_SFT,
        OP_LD,
        OP_CLR
    } op_e;

    // Strobes collapse to one op per cycle: clr > ld > sft > hold.
    function automatic op_e decode_op(input logic clr, input logic ld, input logic sft);
        if (clr) return OP_CLR;
        if (ld)  return OP_LD;
        if (sft) return OP_SFT;
        return OP_HOLD;
    endfunction

endpackage

// File: rtl/booth_shreg_if.sv
// Strobe/data bundle for booth_shreg; shl exists only with BOOTH_SHREG_SHL_EN.
interface booth_shreg_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic [WIDTH-1:0] din;
    logic             ld;
    logic             clr;
    logic             sft;
    logic             sin;
    logic             arith;
`ifdef BOOTH_SHREG_SHL_EN
    logic             shl;
`endif
    logic [WIDTH-1:0] dout;
    logic             qm1;
    logic [CNT_W-1:0] cnt;
    logic             done;

    modport master (
        output din, ld, clr, sft, sin, arith,
`ifdef BOOTH_SHREG_SHL_EN
        output shl,
`endif
        input  dout, qm1, cnt, done
    );

    modport slave (
        input  din, ld, clr, sft, sin, arith,
`ifdef BOOTH_SHREG_SHL_EN
        input  shl,
`endif
        output dout, qm1, cnt, done
    );
endinterface

// File: rtl/booth_stepcnt.sv
// Loadable down-counter of remaining shift steps; sticks at zero, done = (cnt == 0).
module booth_stepcnt #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             ld,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 cnt <= '0;
        else if (clr)               cnt <= '0;
        else if (ld)                cnt <= CNT_W'(WIDTH);
        else if (dec && cnt != '0)  cnt <= cnt - CNT_W'(1);
    end

    assign done = (cnt == '0);
endmodule

// File: rtl/booth_shreg.sv
// Booth multiplier shift register with Q-1 tracking and step counter.
// Optional BOOTH_SHREG_SHL_EN adds a logical left shift selected by shl.
module booth_shreg
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_W,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    booth_shreg_if.slave   bus
);
    op_e              op;
    logic [WIDTH-1:0] dout_q;
    logic             qm1_q;
    logic             msb_in;

    assign op     = decode_op(bus.clr, bus.ld, bus.sft);
    assign msb_in = bus.arith ? dout_q[WIDTH-1] : bus.sin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
            qm1_q  <= 1'b0;
        end else begin
            case (op)
                OP_CLR: begin
                    dout_q <= '0;
                    qm1_q  <= 1'b0;
                end
                OP_LD: begin
                    dout_q <= bus.din;
                    qm1_q  <= 1'b0;
                end
                OP_SFT: begin
                    // Once the step budget is spent, shifts are ignored.
                    if (!bus.done) begin
`ifdef BOOTH_SHREG_SHL_EN
                        if (bus.shl) begin
                            dout_q <= {dout_q[WIDTH-2:0], bus.sin};
                            qm1_q  <= dout_q[WIDTH-1];
                        end else
`endif
                        begin
                            dout_q <= {msb_in, dout_q[WIDTH-1:1]};
                            qm1_q  <= dout_q[0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    booth_stepcnt #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_stepcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (op == OP_CLR),
        .ld    (op == OP_LD),
        .dec   (op == OP_SFT),
        .cnt   (bus.cnt),
        .done  (bus.done)
    );

    assign bus.dout = dout_q;
    assign bus.qm1  = qm1_q;
endmodule
